// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the E stage.
// Owns the HI/LO architectural registers, runs a fixed-latency mult or div on
// operands captured at issue, and asks the hazard unit to stall a D-stage
// HI/LO instruction while the unit is occupied.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,     // asynchronous, active-low
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  md_op_e           op;

  assign op = md_op_e'(md_op);

  // ---------------------------------------------------------------------------
  // Result datapath, driven only by the operands captured at issue
  // ---------------------------------------------------------------------------
  logic        [63:0] mul_a_ext, mul_b_ext, prod;
  logic        [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, div_q, div_r;
  logic               neg_q, neg_r, div_by_zero;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned interpretations.
  assign mul_a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod      = mul_a_ext * mul_b_ext;

  // Signed divide is done on magnitudes: quotient is negative when the operand
  // signs differ, remainder follows the dividend. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 with no special casing.
  assign neg_r       = sgn_q & a_q[31];
  assign neg_q       = sgn_q & (a_q[31] ^ b_q[31]);
  assign a_mag       = neg_r ? (~a_q + 32'd1) : a_q;
  assign b_mag       = (sgn_q & b_q[31]) ? (~b_q + 32'd1) : b_q;
  assign div_by_zero = (b_q == 32'd0);
  assign b_safe      = div_by_zero ? 32'd1 : b_mag;
  assign q_mag       = a_mag / b_safe;
  assign r_mag       = a_mag % b_safe;
  assign div_q       = div_by_zero ? 32'hFFFF_FFFF : (neg_q ? (~q_mag + 32'd1) : q_mag);
  assign div_r       = div_by_zero ? a_q           : (neg_r ? (~r_mag + 32'd1) : r_mag);

  // ---------------------------------------------------------------------------
  // Next-state logic: issue, countdown, and HI/LO write-back
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OP_MULT);
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              state_d = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OP_DIV);
              cnt_d   = CNT_W'(DIV_CYCLES - 1);
              state_d = ST_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;  // none / reserved: ignored
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == '0) begin
          hi_d    = div_r;
          lo_d    = div_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, captured operands and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all of these are plain flops, so every one is reset; reset must
    // also abandon an in-flight operation without touching HI/LO afterwards.
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  // Covers the issue cycle too, so an mfhi right behind a mult is held from the
  // first cycle.
  assign stall_md = d_is_md & (busy | start);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases followed by random
// operations, all compared against an arithmetic model of HI/LO and latency.
`timescale 1ns/1ps
module tb_mdu_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        d_is_md = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_md;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_sequencer #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .a       (a),
    .b       (b),
    .d_is_md (d_is_md),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Architectural result of one operation, from the instruction definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] rh, output logic [31:0] rl, output int cycles);
    longint sx, sy, q, r, p;
    rh = exp_hi;
    rl = exp_lo;
    cycles = 0;
    case (op)
      3'd1: begin
        p = longint'($signed(x)) * longint'($signed(y));
        rh = p[63:32]; rl = p[31:0]; cycles = MULT_N;
      end
      3'd2: begin
        p = longint'(x) * longint'(y);
        rh = p[63:32]; rl = p[31:0]; cycles = MULT_N;
      end
      3'd3, 3'd4: begin
        cycles = DIV_N;
        if (y == 32'd0) begin
          rh = x; rl = 32'hFFFF_FFFF;
        end else begin
          sx = (op == 3'd3) ? longint'($signed(x)) : longint'(x);
          sy = (op == 3'd3) ? longint'($signed(y)) : longint'(y);
          q = sx / sy;
          r = sx % sy;
          rh = r[31:0]; rl = q[31:0];
        end
      end
      3'd5: rh = x;
      3'd6: rl = x;
      default: ;
    endcase
  endtask

  // Issue one operation in the cycle after a rising edge, then follow it to
  // completion checking busy, stall and HI/LO each cycle.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic d, input bit inject);
    logic [31:0] rh, rl;
    int n;
    model(op, x, y, rh, rl, n);
    start = 1'b1; md_op = op; a = x; b = y; d_is_md = d;
    #1;
    check({tag, ".stall_issue"}, 32'(stall_md), 32'(d));
    check({tag, ".busy_issue"},  32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'($urandom); a = $urandom; b = $urandom;
    for (int k = 0; k < n; k++) begin
      if (inject && k == 2) begin
        start = 1'b1; md_op = 3'd5; a = 32'hDEAD_BEEF;
      end
      #1;
      check({tag, ".busy_run"},  32'(busy), 32'd1);
      check({tag, ".stall_run"}, 32'(stall_md), 32'(d));
      check({tag, ".hi_hold"},   hi, exp_hi);
      check({tag, ".lo_hold"},   lo, exp_lo);
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
    end
    exp_hi = rh;
    exp_lo = rl;
    #1;
    check({tag, ".busy_done"},  32'(busy), 32'd0);
    check({tag, ".stall_done"}, 32'(stall_md), 32'd0);
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    // Reset state
    d_is_md = 1'b1;
    #1;
    check("reset.busy",  32'(busy), 32'd0);
    check("reset.hi",    hi, 32'd0);
    check("reset.lo",    lo, 32'd0);
    check("reset.stall", 32'(stall_md), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    d_is_md = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_op("mult",      3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1);
    check("mult.hi_val", hi, 32'hFFFF_FFFF);
    check("mult.lo_val", lo, 32'hFFFF_FFFE);
    do_op("multu",     3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    check("multu.hi_val", hi, 32'h0000_0001);
    do_op("div",       3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    check("div.lo_val", lo, 32'hFFFF_FFFD);
    check("div.hi_val", hi, 32'hFFFF_FFFF);
    do_op("divu_zero", 3'd4, 32'd7, 32'd0, 1'b0, 1'b1);
    check("divu_zero.lo_val", lo, 32'hFFFF_FFFF);
    do_op("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf.lo_val", lo, 32'h8000_0000);
    do_op("div_zero",  3'd3, 32'h8000_0005, 32'd0, 1'b1, 1'b0);
    do_op("mthi",      3'd5, 32'h0000_1234, 32'd0, 1'b1, 1'b0);
    do_op("mtlo",      3'd6, 32'h0000_5678, 32'd0, 1'b1, 1'b0);
    check("mthi.hi_val", hi, 32'h0000_1234);
    check("mtlo.lo_val", lo, 32'h0000_5678);
    do_op("none",      3'd0, 32'hAAAA_AAAA, 32'd3, 1'b0, 1'b0);
    do_op("rsvd",      3'd7, 32'h5555_5555, 32'd3, 1'b0, 1'b0);

    // Idle with a D-stage HI/LO instruction but no issue: no stall
    d_is_md = 1'b1;
    #1;
    check("idle.stall", 32'(stall_md), 32'd0);
    @(posedge clk); #1;
    d_is_md = 1'b0;

    // Random operations, with occasional corner operands
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 16));
        default: ;
      endcase
      do_op("rand", rop, ra, rb, 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of a divide
    start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid.busy", 32'(busy), 32'd0);
    check("rst_mid.hi",   hi, 32'd0);
    check("rst_mid.lo",   lo, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < DIV_N + 3; k++) begin
      @(posedge clk); #1;
      check("rst_after.busy", 32'(busy), 32'd0);
      check("rst_after.hi",   hi, exp_hi);
      check("rst_after.lo",   lo, exp_lo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
